// File: rtl/serial_comparator_nb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : serial_comparator_nb_if                                |
// | Description : Start/busy/done handshake, operands and one-hot result |
// |               lines for the bit-serial magnitude comparator.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface serial_comparator_nb_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             A_great_B;
  logic             A_equals_B;
  logic             A_less_B;

  // Requester side: issues operands and start, observes status and result
  modport master (
    output start, A, B,
    input  busy, done, A_great_B, A_equals_B, A_less_B
  );

  // Comparator side
  modport slave (
    input  start, A, B,
    output busy, done, A_great_B, A_equals_B, A_less_B
  );
endinterface
`default_nettype wire

// File: rtl/serial_comparator_nb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : serial_comparator_nb                                   |
// | Description : WIDTH-bit magnitude comparator, MSB-first bit-serial   |
// |               with early exit at the first differing bit; unsigned   |
// |               or two's-complement. Built on a 1-bit comparator cell. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+

// 1-bit comparator cell: purely combinational, unsigned single bit.
module serial_comparator_nb_bitcell (
  input  wire logic a_i,
  input  wire logic b_i,
  output logic      gt_o,
  output logic      eq_o,
  output logic      lt_o
);
  assign gt_o = a_i & ~b_i;
  assign eq_o = ~(a_i ^ b_i);
  assign lt_o = ~a_i & b_i;
endmodule

module serial_comparator_nb #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  serial_comparator_nb_if.slave bus
);

  localparam int                IDXW    = $clog2(WIDTH);
  localparam logic [IDXW-1:0]   IDX_MSB = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDXW-1:0]  idx_q;
  logic [IDXW-1:0]  idx_d;
  logic             busy_q;
  logic             done_q;
  logic             gt_q;
  logic             eq_q;
  logic             lt_q;

  logic             bit_gt;
  logic             bit_eq;
  logic             bit_lt;
  logic             swap_sign;
  logic             eff_gt;
  logic             eff_lt;

  serial_comparator_nb_bitcell u_cell (
    .a_i  (a_q[idx_q]),
    .b_i  (b_q[idx_q]),
    .gt_o (bit_gt),
    .eq_o (bit_eq),
    .lt_o (bit_lt)
  );

  // In two's-complement mode a set MSB marks the negative (smaller) operand,
  // so the cell's verdict is inverted at the sign position only.
  assign swap_sign = (SIGNED != 0) && (idx_q == IDX_MSB);
  assign eff_gt    = swap_sign ? bit_lt : bit_gt;
  assign eff_lt    = swap_sign ? bit_gt : bit_lt;
  assign idx_d     = idx_q - 1'b1;

  // Control FSM: operand capture, MSB-first scan with early exit, registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          // DONE accepts a new start exactly like IDLE for back-to-back use
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            idx_q   <= IDX_MSB;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CMP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CMP: begin
          if (!bit_eq) begin
            gt_q    <= eff_gt;
            lt_q    <= eff_lt;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (idx_q == '0) begin
            eq_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_d;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.A_great_B  = gt_q;
  assign bus.A_equals_B = eq_q;
  assign bus.A_less_B   = lt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_comparator_nb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_serial_comparator_nb                                |
// | Description : Directed bench for serial_comparator_nb, one unsigned  |
// |               and one signed instance, queue-based scoreboard.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_serial_comparator_nb;

  localparam int W = 8;

  typedef struct {
    logic [2:0] res;   // {gt, eq, lt}
    int         lat;   // cycles from accepting edge to done
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  serial_comparator_nb_if #(.WIDTH(W)) bus0 ();
  serial_comparator_nb_if #(.WIDTH(W)) bus1 ();

  serial_comparator_nb #(.WIDTH(W), .SIGNED(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  serial_comparator_nb #(.WIDTH(W), .SIGNED(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: native comparison operators plus highest-differing-bit latency
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    exp_t e;
    int   m;
    bit   hit;
    logic gt;
    logic lt;
    m   = W;
    hit = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!hit && a[i] != b[i]) begin
        m   = W - i;
        hit = 1'b1;
      end
    end
    gt    = sgn ? ($signed(a) > $signed(b)) : (a > b);
    lt    = sgn ? ($signed(a) < $signed(b)) : (a < b);
    e.res = {gt, (a == b), lt};
    e.lat = m + 1;
    return e;
  endfunction

  function automatic logic [2:0] rd_res(input bit sgn);
    return sgn ? {bus1.A_great_B, bus1.A_equals_B, bus1.A_less_B}
               : {bus0.A_great_B, bus0.A_equals_B, bus0.A_less_B};
  endfunction

  function automatic logic rd_done(input bit sgn);
    return sgn ? bus1.done : bus0.done;
  endfunction

  function automatic logic rd_busy(input bit sgn);
    return sgn ? bus1.busy : bus0.busy;
  endfunction

  task automatic drive(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b, input logic st);
    if (sgn) begin
      bus1.A = a; bus1.B = b; bus1.start = st;
    end else begin
      bus0.A = a; bus0.B = b; bus0.start = st;
    end
  endtask

  // One compare; optional poke changes A and pulses start while busy.
  task automatic run_cmp(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    exp_t e;
    bit   found;
    sb.push_back(model(a, b, sgn));
    @(posedge clk); #1;
    drive(sgn, a, b, 1'b1);
    @(posedge clk); #1;
    drive(sgn, a, b, 1'b0);
    found = 1'b0;
    for (int cyc = 1; cyc <= W + 4 && !found; cyc++) begin
      @(negedge clk);
      if (rd_done(sgn)) begin
        found = 1'b1;
        e = sb.pop_front();
        check("latency", cyc, e.lat);
        check("result", {29'd0, rd_res(sgn)}, {29'd0, e.res});
        check("busy_at_done", {31'd0, rd_busy(sgn)}, 32'd0);
      end else begin
        check("busy_mid", {31'd0, rd_busy(sgn)}, 32'd1);
        check("res_mid", {29'd0, rd_res(sgn)}, 32'd0);
      end
      if (poke && cyc == 1) drive(sgn, 8'hFF, b, 1'b1);
      if (poke && cyc == 2) drive(sgn, 8'hFF, b, 1'b0);
    end
    check("done_seen", {31'd0, found}, 32'd1);
  endtask

  initial begin
    int   ndone;
    int   prev;
    exp_t e;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(0, '0, '0, 1'b0);
    drive(1, '0, '0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy0", {31'd0, bus0.busy}, 32'd0);
    check("rst_done0", {31'd0, bus0.done}, 32'd0);
    check("rst_res0", {29'd0, rd_res(0)}, 32'd0);
    check("rst_res1", {29'd0, rd_res(1)}, 32'd0);
    rst_n = 1'b1;

    // Directed compares from the plan
    run_cmp(0, 8'h00, 8'h00, 0);
    run_cmp(0, 8'h80, 8'h7F, 0);
    run_cmp(1, 8'h80, 8'h7F, 0);
    run_cmp(1, 8'hFE, 8'hFF, 0);
    run_cmp(0, 8'h35, 8'h34, 0);

    // Start/operand changes while busy are ignored; result then holds
    run_cmp(0, 8'h10, 8'h20, 1);
    repeat (3) @(negedge clk);
    check("hold_res", {29'd0, rd_res(0)}, 32'h1);
    check("hold_done", {31'd0, bus0.done}, 32'd0);
    run_cmp(0, 8'hC3, 8'hC3, 0);

    // Back-to-back with start held high
    sb.push_back(model(8'h80, 8'h00, 0));
    sb.push_back(model(8'h00, 8'h80, 0));
    @(posedge clk); #1;
    drive(0, 8'h80, 8'h00, 1'b1);
    @(posedge clk); #1;
    drive(0, 8'h00, 8'h80, 1'b1);
    ndone = 0;
    prev  = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (bus0.done) begin
        ndone++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("b2b_latency", cyc - prev, e.lat);
          check("b2b_result", {29'd0, rd_res(0)}, {29'd0, e.res});
        end
        prev = cyc;
      end
      if (cyc == 3) drive(0, 8'h00, 8'h80, 1'b0);
    end
    check("b2b_done_count", ndone, 2);

    // Asynchronous reset in the middle of an equal-operand compare
    @(posedge clk); #1;
    drive(0, 8'h00, 8'h00, 1'b1);
    @(posedge clk); #1;
    drive(0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_abort_busy", {31'd0, bus0.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus0.busy}, 32'd0);
    check("abort_done", {31'd0, bus0.done}, 32'd0);
    check("abort_res", {29'd0, rd_res(0)}, 32'd0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus0.done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    rst_n = 1'b1;
    run_cmp(0, 8'h01, 8'h01, 0);

    // A few random operands on both instances
    for (int i = 0; i < 8; i++) begin
      run_cmp(i[0], 8'($urandom), 8'($urandom), 0);
    end

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
